addsub_serial: RTL and testbench

Parametrised multi-cycle adder/subtractor that succeeds the single-cycle combinational `addsub` unit. It processes a WIDTH-bit add or subtract CHUNK bits per clock, carrying between slices, and returns the same four ALU flags (carry/borrow, signed overflow, sign, zero). It sits beside the ALU datapath where area matters more than latency, and uses a start/busy/done handshake.

---
 rtl/addsub_serial_if.sv | 28 ++
 rtl/addsub_serial.sv | 114 +++++++++++
 tb/tb_addsub_serial.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/addsub_serial_if.sv
// addsub_serial_if: start/busy/done handshake bundle for addsub_serial.
//   master: drives start, a, b, sub; observes busy, done, sum and the four flags.
//   slave : the serial adder/subtractor side.
interface addsub_serial_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cf;
  logic             ovf;
  logic             sf;
  logic             zf;

  modport master (
    output start, a, b, sub,
    input  busy, done, sum, cf, ovf, sf, zf
  );

  modport slave (
    input  start, a, b, sub,
    output busy, done, sum, cf, ovf, sf, zf
  );
endinterface

// File: rtl/addsub_serial.sv
// addsub_serial: multi-cycle WIDTH-bit adder/subtractor processing CHUNK bits
// per clock, returning carry/borrow, signed overflow, sign and zero flags.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of addsub_serial_if
//           start/a/b/sub in; busy, done (1-cycle pulse), sum, cf, ovf, sf, zf out.
// Results and flags are held registers, updated only on the completing edge.
module addsub_serial #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input logic           clk,
  input logic           rst_n,
  addsub_serial_if.slave bus
);

  localparam int unsigned N  = WIDTH / CHUNK;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] opa, opb, acc, acc_d;
  logic             carry, sub_q, last;
  logic [CW-1:0]    cnt;
  logic [CHUNK:0]   slice_sum;

  logic [WIDTH-1:0] sum_q;
  logic             cf_q, ovf_q, sf_q, zf_q, done_q;

  always_comb begin
    state_d   = state;
    last      = 1'b0;
    slice_sum = {1'b0, opa[CHUNK-1:0]} + {1'b0, opb[CHUNK-1:0]} + (CHUNK+1)'(carry);
    // Slices enter at the top and move down, so after N slices slice 0 sits at bit 0.
    acc_d     = (acc >> CHUNK) | (WIDTH'(slice_sum[CHUNK-1:0]) << (WIDTH - CHUNK));
    case (state)
      IDLE: if (bus.start) state_d = RUN;
      RUN: begin
        if (cnt == CW'(N - 1)) begin
          last    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa    <= '0;
      opb    <= '0;
      acc    <= '0;
      carry  <= 1'b0;
      sub_q  <= 1'b0;
      cnt    <= '0;
      sum_q  <= '0;
      cf_q   <= 1'b0;
      ovf_q  <= 1'b0;
      sf_q   <= 1'b0;
      zf_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            opa   <= bus.a;
            opb   <= bus.sub ? ~bus.b : bus.b;
            carry <= bus.sub;
            sub_q <= bus.sub;
            cnt   <= '0;
            acc   <= '0;
          end
        end
        RUN: begin
          opa   <= opa >> CHUNK;
          opb   <= opb >> CHUNK;
          carry <= slice_sum[CHUNK];
          acc   <= acc_d;
          cnt   <= cnt + CW'(1);
          if (last) begin
            // On the final slice the operand registers' top slice bit is the
            // original MSB of a and of the effective b.
            sum_q  <= acc_d;
            cf_q   <= slice_sum[CHUNK] ^ sub_q;
            ovf_q  <= (opa[CHUNK-1] == opb[CHUNK-1]) && (acc_d[WIDTH-1] != opa[CHUNK-1]);
            sf_q   <= acc_d[WIDTH-1];
            zf_q   <= (acc_d == '0);
            done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cf   = cf_q;
  assign bus.ovf  = ovf_q;
  assign bus.sf   = sf_q;
  assign bus.zf   = zf_q;

endmodule

// File: tb/tb_addsub_serial.sv
module tb_addsub_serial;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  addsub_serial_if #(.WIDTH(32)) bus32 ();
  addsub_serial_if #(.WIDTH(16)) bus16 ();

  addsub_serial #(.WIDTH(32), .CHUNK(8)) dut32 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus32.slave)
  );

  addsub_serial #(.WIDTH(16), .CHUNK(16)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus16.slave)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] s;
    logic        cf;
    logic        ovf;
    logic        sf;
    logic        zf;
  } vec_t;

  int tests = 0;
  int failed = 0;
  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic get_done(input bit sm, output logic d);
    d = sm ? bus16.done : bus32.done;
  endtask

  task automatic get_busy(input bit sm, output logic bz);
    bz = sm ? bus16.busy : bus32.busy;
  endtask

  task automatic chk_res(input string nm, input bit sm, input logic [31:0] s,
                         input logic cf, input logic ovf, input logic sf, input logic zf);
    if (sm) begin
      chk({nm, ".sum"}, {16'h0, bus16.sum}, s);
      chk({nm, ".cf"},  {31'h0, bus16.cf},  {31'h0, cf});
      chk({nm, ".ovf"}, {31'h0, bus16.ovf}, {31'h0, ovf});
      chk({nm, ".sf"},  {31'h0, bus16.sf},  {31'h0, sf});
      chk({nm, ".zf"},  {31'h0, bus16.zf},  {31'h0, zf});
    end else begin
      chk({nm, ".sum"}, bus32.sum, s);
      chk({nm, ".cf"},  {31'h0, bus32.cf},  {31'h0, cf});
      chk({nm, ".ovf"}, {31'h0, bus32.ovf}, {31'h0, ovf});
      chk({nm, ".sf"},  {31'h0, bus32.sf},  {31'h0, sf});
      chk({nm, ".zf"},  {31'h0, bus32.zf},  {31'h0, zf});
    end
  endtask

  // Drive start for one edge; returns at accept edge + 1.
  task automatic issue(input string nm, input bit sm, input logic [31:0] a,
                       input logic [31:0] b, input logic sub);
    logic bz, d;
    @(negedge clk);
    if (sm) begin
      bus16.start = 1'b1; bus16.a = a[15:0]; bus16.b = b[15:0]; bus16.sub = sub;
    end else begin
      bus32.start = 1'b1; bus32.a = a; bus32.b = b; bus32.sub = sub;
    end
    @(posedge clk);
    #1;
    bus32.start = 1'b0;
    bus16.start = 1'b0;
    get_busy(sm, bz);
    get_done(sm, d);
    chk({nm, ".busy_after_accept"}, {31'h0, bz}, 32'd1);
    chk({nm, ".done_after_accept"}, {31'h0, d}, 32'd0);
  endtask

  // Count edges until done, bounded; timeout shows up as a latency mismatch.
  task automatic wait_done(input bit sm, output int lat);
    logic d;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      get_done(sm, d);
    end while (!d && lat < 20);
    if (!d) lat = 99;
  endtask

  task automatic run_vec(input string nm, input bit sm, input vec_t v, input int exp_lat);
    int lat;
    logic d, bz;
    issue(nm, sm, v.a, v.b, v.sub);
    wait_done(sm, lat);
    chk({nm, ".latency"}, lat, exp_lat);
    get_busy(sm, bz);
    chk({nm, ".busy_in_done"}, {31'h0, bz}, 32'd0);
    chk_res(nm, sm, v.s, v.cf, v.ovf, v.sf, v.zf);
    @(posedge clk);
    #1;
    get_done(sm, d);
    chk({nm, ".done_pulse_end"}, {31'h0, d}, 32'd0);
    chk_res({nm, ".hold"}, sm, v.s, v.cf, v.ovf, v.sf, v.zf);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, ndone, first;
    logic d;
    vec_t v;

    //          a             b             sub  sum           cf    ovf   sf    zf
    vecs[0] = '{32'd16,       32'd12,       1'b0, 32'd28,      1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{32'd16,       32'd12,       1'b1, 32'd4,       1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{32'h16,       32'h17,       1'b1, 32'hFFFFFFFF,1'b1, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{32'h7FFFFFFF, 32'd2,        1'b0, 32'h80000001,1'b0, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{32'hFFFFFFFF, 32'd1,        1'b0, 32'h0,       1'b1, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{32'h80000000, 32'd1,        1'b1, 32'h7FFFFFFF,1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{32'h12345678, 32'h0FEDCBA9, 1'b0, 32'h22222221,1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{32'd5,        32'd5,        1'b1, 32'h0,       1'b0, 1'b0, 1'b0, 1'b1};

    bus32.start = 1'b0; bus32.a = '0; bus32.b = '0; bus32.sub = 1'b0;
    bus16.start = 1'b0; bus16.a = '0; bus16.b = '0; bus16.sub = 1'b0;

    #12;
    chk("reset.busy", {31'h0, bus32.busy}, 32'd0);
    chk("reset.done", {31'h0, bus32.done}, 32'd0);
    chk_res("reset", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_vec($sformatf("vec%0d", i), 1'b0, vecs[i], 4);
    end

    // Start pulsed two cycles into an operation, with new operands: ignored.
    issue("ign", 1'b0, 32'h100, 32'h23, 1'b0);
    @(posedge clk);
    @(negedge clk);
    bus32.start = 1'b1; bus32.a = 32'hAAAAAAAA; bus32.b = 32'h5555; bus32.sub = 1'b1;
    @(posedge clk);
    #1;
    bus32.start = 1'b0;
    chk("ign.busy_held", {31'h0, bus32.busy}, 32'd1);
    ndone = 0;
    first = -1;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk);
      #1;
      if (bus32.done) begin
        ndone++;
        if (first < 0) first = i;
      end
    end
    chk("ign.done_count", ndone, 1);
    chk("ign.done_edge", first, 2);
    chk_res("ign", 1'b0, 32'h123, 1'b0, 1'b0, 1'b0, 1'b0);

    // Back-to-back: start asserted during the done cycle.
    issue("b2b1", 1'b0, 32'h1000, 32'h0234, 1'b0);
    wait_done(1'b0, lat);
    chk("b2b1.latency", lat, 4);
    chk_res("b2b1", 1'b0, 32'h1234, 1'b0, 1'b0, 1'b0, 1'b0);
    issue("b2b2", 1'b0, 32'h0, 32'h1, 1'b1);
    wait_done(1'b0, lat);
    chk("b2b2.latency", lat, 4);
    chk_res("b2b2", 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 1'b0);

    // Reset two cycles into an operation.
    issue("rst", 1'b0, 32'h1111, 32'h2222, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst.busy", {31'h0, bus32.busy}, 32'd0);
    chk("rst.done", {31'h0, bus32.done}, 32'd0);
    chk_res("rst", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      get_done(1'b0, d);
      if (d) ndone++;
    end
    chk("rst.no_done", ndone, 0);
    chk("rst.idle", {31'h0, bus32.busy}, 32'd0);
    v = '{32'hFFFF, 32'd1, 1'b0, 32'h10000, 1'b0, 1'b0, 1'b0, 1'b0};
    run_vec("post_rst", 1'b0, v, 4);

    // Single-slice instance.
    v = '{32'h8000, 32'd1, 1'b1, 32'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0};
    run_vec("w16_sub", 1'b1, v, 1);
    v = '{32'hFFFF, 32'd1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1};
    run_vec("w16_add", 1'b1, v, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
